reg_save_restore: RTL



---
 rtl/reg_save_restore.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/reg_save_restore.sv
// Register-block save/restore sequencer between an 8-entry register file and data memory.
// Optional macro SAVE_RESTORE_CHECKSUM_EN adds CHECKSUM, the XOR of every transferred byte.
module reg_save_restore #(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 3,
  parameter int unsigned MAW = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           START,
  input  logic           MODE,
  input  logic [AW-1:0]  FIRST_REG,
  input  logic [3:0]     COUNT,
  input  logic [MAW-1:0] BASE_ADDR,
  output logic           BUSY,
  output logic           DONE,
  output logic [AW-1:0]  REG_RADDR,
  input  logic [DW-1:0]  REG_RDATA,
  output logic [AW-1:0]  REG_WADDR,
  output logic [DW-1:0]  REG_WDATA,
  output logic           REG_WRITE,
  output logic           MEM_READ,
  output logic           MEM_WRITE,
  output logic [MAW-1:0] MEM_ADDRESS,
  output logic [DW-1:0]  MEM_WRITEDATA,
  input  logic [DW-1:0]  MEM_READDATA,
`ifdef SAVE_RESTORE_CHECKSUM_EN
  output logic [DW-1:0]  CHECKSUM,
`endif
  input  logic           MEM_BUSYWAIT
);

  typedef enum logic [2:0] {
    StIdle,
    StSrd,
    StSwr,
    StRrd,
    StRwr,
    StFin
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     n_q, n_d;
  logic [AW-1:0]  first_q, first_d;
  logic [MAW-1:0] base_q, base_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [AW-1:0]  reg_raddr_q, reg_raddr_d;
  logic [AW-1:0]  reg_waddr_q, reg_waddr_d;
  logic [DW-1:0]  reg_wdata_q, reg_wdata_d;
  logic           reg_write_q, reg_write_d;
  logic           mem_read_q, mem_read_d;
  logic           mem_write_q, mem_write_d;
  logic [MAW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0]  mem_writedata_q, mem_writedata_d;

  logic [2:0]     idx_nxt;
  logic           is_last;

  assign idx_nxt = idx_q + 3'd1;
  assign is_last = ({1'b0, idx_q} == (n_q - 4'd1));

  // Outputs are computed for the state being entered, so every output is a plain flop.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    n_d             = n_q;
    first_d         = first_q;
    base_d          = base_q;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    reg_write_d     = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    reg_raddr_d     = reg_raddr_q;
    reg_waddr_d     = reg_waddr_q;
    reg_wdata_d     = reg_wdata_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          first_d = FIRST_REG;
          base_d  = BASE_ADDR;
          idx_d   = 3'd0;
          n_d     = (COUNT > 4'd8) ? 4'd8 : COUNT;
          if (COUNT == 4'd0) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else if (!MODE) begin
            state_d     = StSrd;
            busy_d      = 1'b1;
            reg_raddr_d = FIRST_REG;
          end else begin
            state_d       = StRrd;
            busy_d        = 1'b1;
            mem_read_d    = 1'b1;
            mem_address_d = BASE_ADDR;
          end
        end
      end

      StSrd: begin
        state_d         = StSwr;
        busy_d          = 1'b1;
        mem_write_d     = 1'b1;
        mem_address_d   = base_q + MAW'(idx_q);
        mem_writedata_d = REG_RDATA;
      end

      StSwr: begin
        if (MEM_BUSYWAIT) begin
          busy_d      = 1'b1;
          mem_write_d = 1'b1;
        end else if (is_last) begin
          state_d = StFin;
          done_d  = 1'b1;
        end else begin
          state_d     = StSrd;
          busy_d      = 1'b1;
          idx_d       = idx_nxt;
          reg_raddr_d = first_q + AW'(idx_nxt);
        end
      end

      StRrd: begin
        busy_d = 1'b1;
        if (MEM_BUSYWAIT) begin
          mem_read_d = 1'b1;
        end else begin
          state_d     = StRwr;
          reg_write_d = 1'b1;
          reg_waddr_d = first_q + AW'(idx_q);
          reg_wdata_d = MEM_READDATA;
        end
      end

      StRwr: begin
        if (is_last) begin
          state_d = StFin;
          done_d  = 1'b1;
        end else begin
          state_d       = StRrd;
          busy_d        = 1'b1;
          idx_d         = idx_nxt;
          mem_read_d    = 1'b1;
          mem_address_d = base_q + MAW'(idx_nxt);
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= StIdle;
      idx_q           <= 3'd0;
      n_q             <= 4'd0;
      first_q         <= '0;
      base_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      reg_raddr_q     <= '0;
      reg_waddr_q     <= '0;
      reg_wdata_q     <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      n_q             <= n_d;
      first_q         <= first_d;
      base_q          <= base_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      reg_raddr_q     <= reg_raddr_d;
      reg_waddr_q     <= reg_waddr_d;
      reg_wdata_q     <= reg_wdata_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign REG_RADDR     = reg_raddr_q;
  assign REG_WADDR     = reg_waddr_q;
  assign REG_WDATA     = reg_wdata_q;
  assign REG_WRITE     = reg_write_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

`ifdef SAVE_RESTORE_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  // Fold in each byte on the same edge that captures it.
  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && START) begin
      csum_d = '0;
    end else if (state_q == StSrd) begin
      csum_d = csum_q ^ REG_RDATA;
    end else if (state_q == StRrd && !MEM_BUSYWAIT) begin
      csum_d = csum_q ^ MEM_READDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign CHECKSUM = csum_q;
`endif

endmodule
